mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_rr_pick.sv | 35 +++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : femto_arb_pkg
// Brief  : Shared constants for the memory-port arbiter: requester count,
//          select width, FSM state encoding and the watchdog default limit.
// Rev    : 1.0  initial release
// ============================================================================
package femto_arb_pkg;

  localparam int NUM_REQ                = 8;
  localparam int SEL_W                  = 3;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 1'b0;
  localparam arb_state_t ST_BUSY = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin search. Scans req starting at ptr and
//          ascending with wrap-around; the first set bit wins.
// Ports  : req   - request vector, bit i = requester i
//          ptr   - index the search starts at
//          found - at least one request is set
//          idx   - winning requester index (0 when found is low)
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick
  import femto_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  // Walk the rotation from the far end back towards ptr so the nearest
  // set bit is the last one written and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        found = 1'b1;
        idx   = ptr + SEL_W'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Round-robin arbiter granting one of eight requesters access to a
//          shared memory port. A grant is held until done; the next winner
//          is granted on the same edge (back-to-back) when requests remain.
//          Optional grant watchdog enabled by macro ARB_TIMEOUT_EN.
// Ports  : clk     - clock, rising edge
//          rst_n   - synchronous active-low reset
//          req     - request vector, bit i = requester i
//          done    - completion pulse for the current grant
//          grant   - one-hot registered grant
//          sel     - registered binary index of the granted requester
//          busy    - a grant is active
//          timeout - one-cycle pulse when the watchdog revokes a grant
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int NUM_REQ        = femto_arb_pkg::NUM_REQ,
  parameter int TIMEOUT_CYCLES = femto_arb_pkg::TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic                            done,
  output logic [NUM_REQ-1:0]              grant,
  output logic [femto_arb_pkg::SEL_W-1:0] sel,
  output logic                            busy,
  output logic                            timeout
);

  import femto_arb_pkg::*;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  w_grant_nxt;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [SEL_W-1:0]    r_ptr;
  logic [SEL_W-1:0]    w_ptr_nxt;
  logic [SEL_W-1:0]    w_pick_ptr;
  logic [SEL_W-1:0]    w_idx;
  logic                w_found;
  logic                w_expire;
  logic                w_release;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_wdog;

  // Done wins over a coinciding expiry, so expiry is only seen without done.
  assign w_expire = (r_state == ST_BUSY) && !done &&
                    (r_wdog == 8'(TIMEOUT_CYCLES - 1));

  // Counts BUSY cycles of the current grant; any release starts a fresh count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if ((r_state == ST_IDLE) || w_release) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 8'd1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^TIMEOUT_CYCLES[7:0];
  assign w_expire     = 1'b0;
`endif

  assign w_release = (r_state == ST_BUSY) && (done || w_expire);

  // While busy the stored ptr is stale: the owner goes to the back of the
  // rotation, so the search for the successor starts just past it.
  assign w_pick_ptr = (r_state == ST_BUSY) ? (r_sel + SEL_W'(1)) : r_ptr;

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (w_pick_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_release && !w_found) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt = NUM_REQ'(1) << w_idx;
          w_sel_nxt   = w_idx;
        end else begin
          w_grant_nxt = '0;
          w_sel_nxt   = '0;
        end
      end
      ST_BUSY: begin
        if (w_release) begin
          w_ptr_nxt = r_sel + SEL_W'(1);
          if (w_found) begin
            w_grant_nxt = NUM_REQ'(1) << w_idx;
            w_sel_nxt   = w_idx;
          end else begin
            w_grant_nxt = '0;
            w_sel_nxt   = '0;
          end
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_sel_nxt   = '0;
      end
    endcase
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign busy    = |r_grant;
  assign timeout = w_expire;

endmodule
`default_nettype wire
